// File: rtl/config_loader_pkg.sv
// cfg_pkg: state encoding and chain sizing helpers shared with the fabric top.
package cfg_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
  function automatic int n_words(int cfg_bits, int word_w);
    return (cfg_bits + word_w - 1) / word_w;
  endfunction
  function automatic int cnt_w(int cfg_bits);
    return $clog2(cfg_bits + 1);
  endfunction
endpackage

// File: rtl/config_loader_if.sv
// config_loader_if: valid/ready word stream feeding the config loader.
interface config_loader_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/config_loader_piso.sv
// cfg_piso: parallel-load, shift-right register presenting its LSB.
module cfg_piso #(parameter int WORD_W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic [WORD_W-1:0] d,
  output logic q0
);
  logic [WORD_W-1:0] q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {1'b0, q[WORD_W-1:1]};
  assign q0 = q[0];
endmodule

// File: rtl/config_loader.sv
// config_loader: serializes checksummed bitstream words into the config chain.
module config_loader import cfg_pkg::*; #(
  parameter int WORD_W   = 8,
  parameter int CFG_BITS = 20,
  parameter int N_WORDS  = n_words(CFG_BITS, WORD_W),
  parameter int CNT_W    = cnt_w(CFG_BITS)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  config_loader_if.slave bus,
  output logic cfg_dout,
  output logic cfg_shift_en,
  output logic cfg_latch,
  output logic busy,
  output logic done,
  output logic err,
  output logic [CNT_W-1:0] bit_count
);
  localparam int WC_W = $clog2(WORD_W + 1);
  localparam int WI_W = $clog2(N_WORDS + 1);
  localparam logic [WC_W-1:0] FULL_LIM  = WC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] LAST_LIM  = WC_W'(CFG_BITS - (N_WORDS - 1) * WORD_W - 1);
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(N_WORDS - 1);
  logic [2:0] state, nxt;
  logic [WORD_W-1:0] acc;
  logic [WC_W-1:0] wcnt, wlim;
  logic [WI_W-1:0] widx;
  logic hs, load, shifting, word_end, go, kill, q0;
  assign bus.in_ready = state == S_WAIT || state == S_CHECK;
  assign hs       = bus.in_valid && bus.in_ready;
  assign load     = hs && state == S_WAIT;
  assign shifting = state == S_SHIFT;
  // the final word stops at the chain boundary; its pad bits stay in the PISO
  assign wlim     = widx == LAST_WORD ? LAST_LIM : FULL_LIM;
  assign word_end = shifting && wcnt == wlim;
  assign busy     = state inside {S_WAIT, S_SHIFT, S_CHECK, S_LATCH};
  assign kill     = abort && busy;
  assign go       = start && !abort && !busy;
  assign cfg_shift_en = shifting;
  assign cfg_dout     = shifting && q0;
  assign cfg_latch    = state == S_LATCH;
  assign done         = state == S_DONE;
  assign err          = state == S_ERR;
  always_comb begin
    nxt = state;
    if (kill) nxt = S_IDLE;
    else if (go) nxt = S_WAIT;
    else
      case (state)
        S_WAIT:  nxt = hs ? S_SHIFT : S_WAIT;
        S_SHIFT: nxt = word_end ? (widx == LAST_WORD ? S_CHECK : S_WAIT) : S_SHIFT;
        S_CHECK: nxt = hs ? (bus.in_data == acc ? S_LATCH : S_ERR) : S_CHECK;
        S_LATCH: nxt = S_DONE;
        S_IDLE, S_DONE, S_ERR: nxt = state;
        default: nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= S_IDLE;
      bit_count <= '0;
      acc       <= '0;
      wcnt      <= '0;
      widx      <= '0;
    end else begin
      state <= nxt;
      if (go || kill) begin
        bit_count <= '0;
        acc       <= '0;
        wcnt      <= '0;
        widx      <= '0;
      end else if (load) acc <= acc ^ bus.in_data;
      else if (shifting) begin
        bit_count <= bit_count + 1'b1;
        wcnt      <= word_end ? '0 : wcnt + 1'b1;
        widx      <= widx + WI_W'(word_end);
      end
    end
  cfg_piso #(.WORD_W(WORD_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shifting),
    .d     (bus.in_data),
    .q0    (q0)
  );
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed vector table plus abort/reset/start corner sequences.
module tb_config_loader;
  logic clk, rst, start, abort;
  logic cfg_dout, cfg_shift_en, cfg_latch, busy, done, err;
  logic [4:0] bit_count;
  config_loader_if #(.WORD_W(8)) bus ();
  config_loader #(.WORD_W(8), .CFG_BITS(20)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .cfg_dout(cfg_dout), .cfg_shift_en(cfg_shift_en), .cfg_latch(cfg_latch),
    .busy(busy), .done(done), .err(err), .bit_count(bit_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [23:0] words;
    logic [7:0]  cs;
    int          gap;
    logic        poke;
    logic [19:0] stream;
    logic        ok;
  } vec_t;
  vec_t v[8];
  int n_vec = 0, n_bad = 0;
  int n_shift = 0, n_latch = 0, n_ovl = 0;
  logic [63:0] hist = '0;
  // hist[44] is the oldest of the last 20 shifted bits
  always @(negedge clk) begin
    if (cfg_shift_en) begin
      n_shift <= n_shift + 1;
      hist <= {cfg_dout, hist[63:1]};
    end
    if (cfg_latch) n_latch <= n_latch + 1;
    if (cfg_shift_en && bus.in_ready) n_ovl <= n_ovl + 1;
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] w, input int gap, input string name);
    int t, s0;
    if (gap > 0) begin
      t = 0;
      while (!bus.in_ready && t < 100) begin tick(); t++; end
      s0 = n_shift;
      repeat (gap) tick();
      chk({name, "_gap_shift"}, n_shift, s0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    t = 0;
    while (!bus.in_ready && t < 100) begin tick(); t++; end
    if (t >= 100) chk({name, "_ready_timeout"}, 1, 0);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic run_vec(input vec_t x, input int id);
    int s0, l0, t;
    string nm;
    nm = $sformatf("vec%0d", id);
    s0 = n_shift;
    l0 = n_latch;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(x.words[i*8 +: 8], x.gap, nm);
      if (x.poke && i == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    send(x.cs, x.gap, nm);
    t = 0;
    while (!(done || err) && t < 30) begin tick(); t++; end
    chk({nm, "_stream"}, hist[63:44], x.stream);
    chk({nm, "_shifts"}, n_shift - s0, 20);
    chk({nm, "_latches"}, n_latch - l0, x.ok ? 1 : 0);
    chk({nm, "_done"}, done, x.ok);
    chk({nm, "_err"}, err, !x.ok);
    chk({nm, "_bit_count"}, bit_count, 20);
    chk({nm, "_busy"}, busy, 0);
  endtask
  initial begin
    int s0, l0, t;
    v[0] = '{24'h0F3CA5, 8'h96, 0, 1'b0, 20'hF3CA5, 1'b1};
    v[1] = '{24'h0F3CA5, 8'h00, 0, 1'b0, 20'hF3CA5, 1'b0};
    v[2] = '{24'h0F3CA5, 8'h96, 5, 1'b0, 20'hF3CA5, 1'b1};
    v[3] = '{24'hF300FF, 8'h0C, 0, 1'b0, 20'h300FF, 1'b1};
    v[4] = '{24'h563412, 8'h70, 0, 1'b0, 20'h63412, 1'b1};
    v[5] = '{24'hFF3CA5, 8'h96, 0, 1'b0, 20'hF3CA5, 1'b0};
    v[6] = '{24'hFF3CA5, 8'h66, 0, 1'b0, 20'hF3CA5, 1'b1};
    v[7] = '{24'h0F3CA5, 8'h96, 0, 1'b1, 20'hF3CA5, 1'b1};
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_shift_en", cfg_shift_en, 0);
    chk("rst_latch", cfg_latch, 0);
    chk("rst_dout", cfg_dout, 0);
    chk("rst_bit_count", bit_count, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) run_vec(v[i], i);
    // abort after 11 bits, then a clean reload
    s0 = n_shift;
    l0 = n_latch;
    start = 1'b1; tick(); start = 1'b0;
    send(8'hA5, 0, "abort");
    send(8'h3C, 0, "abort");
    t = 0;
    while (n_shift - s0 < 11 && t < 50) begin tick(); t++; end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.in_ready, 0);
    tick(); tick();
    chk("abort_shifts", n_shift - s0, 11);
    chk("abort_latch", n_latch - l0, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    run_vec(v[0], 100);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    chk("abort_wins_done", done, 1);
    chk("abort_wins_busy", busy, 0);
    // reset at bit 4
    s0 = n_shift;
    start = 1'b1; tick(); start = 1'b0;
    send(8'hA5, 0, "rstmid");
    t = 0;
    while (n_shift - s0 < 4 && t < 50) begin tick(); t++; end
    rst = 1'b1; tick();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_shift_en", cfg_shift_en, 0);
    chk("rstmid_dout", cfg_dout, 0);
    chk("rstmid_bit_count", bit_count, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_err", err, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_ready", bus.in_ready, 0);
    chk("rstmid_shifts", n_shift - s0, 4);
    chk("overlap_ready_shift", n_ovl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
